// File: rtl/sub_result_stage.sv
// sub_result_stage
//   Registered result stage behind the 32-bit ripple subtractor. It captures
//   the operands and the subtractor's diff, derives status flags, cross-checks
//   diff against a behavioural A-B, and presents each result on a valid/ready
//   output. A one-entry skid register behind the output register sustains one
//   result per cycle while in_ready stays a plain flop.
//
//   Optional feature: define SUB_STAGE_STICKY_EN to enable the sticky
//   error/overflow indicator. Without it, sticky_err is tied low, clr_sticky
//   is ignored, and both ports remain so the interface is the same either way.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      A/B/diff valid this cycle
//   in_ready   out  1      stage can accept (registered)
//   in_a       in   W      minuend
//   in_b       in   W      subtrahend
//   in_diff    in   W      diff from ripple subtractor
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts
//   out_diff   out  W      registered diff
//   out_flags  out  5      {err,ovf,brw,neg,zero}
//   res_count  out  CNT_W  delivered-result counter, wraps
//   clr_sticky in   1      clears sticky_err
//   sticky_err out  1      sticky err|ovf indicator
module sub_result_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_diff,
    output logic [4:0]       out_flags,
    output logic [CNT_W-1:0] res_count,
    input  logic             clr_sticky,
    output logic             sticky_err
);

    localparam int unsigned FLAG_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       skid_diff;
    logic [FLAG_W-1:0]  skid_flags;
    logic [W-1:0]       ref_diff_c;
    logic [FLAG_W-1:0]  in_flags_c;
    logic               accept_c;
    logic               deliver_c;
    logic               load_out_c;
    logic               load_skid_c;
    logic               move_skid_c;

    // Status flags of the incoming entry; ovf follows the supplied diff's sign.
    always_comb begin
        ref_diff_c = in_a - in_b;
        in_flags_c = {
            (in_diff != ref_diff_c),
            (in_a[W-1] != in_b[W-1]) && (in_diff[W-1] != in_a[W-1]),
            (in_a < in_b),
            in_diff[W-1],
            (in_diff == '0)
        };
    end

    assign accept_c  = in_valid && in_ready;
    assign deliver_c = out_valid && out_ready;

    // Next-state and load controls for output reg + skid reg.
    always_comb begin
        state_nxt   = state;
        load_out_c  = 1'b0;
        load_skid_c = 1'b0;
        move_skid_c = 1'b0;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    load_out_c = 1'b1;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (accept_c && deliver_c) begin
                    load_out_c = 1'b1;
                end else if (accept_c) begin
                    load_skid_c = 1'b1;
                    state_nxt   = FULL;
                end else if (deliver_c) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (deliver_c) begin
                    move_skid_c = 1'b1;
                    state_nxt   = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State, datapath registers and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_flags  <= '0;
            skid_diff  <= '0;
            skid_flags <= '0;
            res_count  <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            if (load_out_c) begin
                out_diff  <= in_diff;
                out_flags <= in_flags_c;
            end else if (move_skid_c) begin
                out_diff  <= skid_diff;
                out_flags <= skid_flags;
            end
            if (load_skid_c) begin
                skid_diff  <= in_diff;
                skid_flags <= in_flags_c;
            end
            if (deliver_c) begin
                res_count <= res_count + CNT_W'(1);
            end
        end
    end

`ifdef SUB_STAGE_STICKY_EN
    // Set by an accepted err|ovf entry; set has priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_err <= 1'b0;
        end else if (accept_c && (in_flags_c[4] || in_flags_c[3])) begin
            sticky_err <= 1'b1;
        end else if (clr_sticky) begin
            sticky_err <= 1'b0;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
module tb_sub_result_stage;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [W-1:0]     in_diff = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_diff;
    logic [4:0]       out_flags;
    logic [CNT_W-1:0] res_count;
    logic             clr_sticky = 1'b0;
    logic             sticky_err;

    sub_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_diff    (in_diff),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_flags  (out_flags),
        .res_count  (res_count),
        .clr_sticky (clr_sticky),
        .sticky_err (sticky_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: flags straight from the rule table.
    function automatic logic [4:0] flags_of(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] d);
        logic err, ovf, brw, neg, zero;
        logic [31:0] true_diff;
        true_diff = a - b;
        zero = (d == 32'd0);
        neg  = d[31];
        brw  = (a < b);
        ovf  = (a[31] != b[31]) && (d[31] != a[31]);
        err  = (d != true_diff);
        return {err, ovf, brw, neg, zero};
    endfunction

    // Behavioural model: a 2-deep FIFO of results, readiness from its depth.
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  f;
    } exp_t;

    exp_t        q[$];
    logic        m_ready  = 1'b0;
    int unsigned m_count  = 0;
    logic        m_sticky = 1'b0;
    bit          started  = 1'b0;

    always @(posedge clk) begin
        bit   acc;
        bit   dlv;
        exp_t e;
        started = 1'b1;
        if (rst) begin
            q.delete();
            m_ready  = 1'b0;
            m_count  = 0;
            m_sticky = 1'b0;
        end else begin
            acc = in_valid && m_ready;
            dlv = (q.size() != 0) && out_ready;
            if (dlv) begin
                void'(q.pop_front());
                m_count = (m_count + 1) % 65536;
            end
            if (acc) begin
                e.d = in_diff;
                e.f = flags_of(in_a, in_b, in_diff);
                q.push_back(e);
            end
`ifdef SUB_STAGE_STICKY_EN
            if (acc && (e.f[4] || e.f[3])) m_sticky = 1'b1;
            else if (clr_sticky)           m_sticky = 1'b0;
`endif
            m_ready = (q.size() < 2);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_diff", out_diff, q[0].d);
                chk("out_flags", 32'(out_flags), 32'(q[0].f));
            end
            chk("res_count", 32'(res_count), m_count);
            chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_diff  = d;
    endtask

    initial begin
        // Reset behaviour
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_out_diff", out_diff, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic subtract, latency 1
        out_ready = 1'b1;
        drive(1'b1, 32'd10, 32'd3, 32'd7);
        cyc();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_diff", out_diff, 32'd7);
        chk("t1_flags", 32'(out_flags), 32'b00000);
        drive(1'b0, '0, '0, '0);
        cyc();
        chk("t1_res_count", 32'(res_count), 32'd1);

        // Borrow/negative, then zero
        drive(1'b1, 32'd3, 32'd10, 32'hFFFF_FFF9);
        cyc();
        chk("t2_brw_neg", 32'(out_flags), 32'b00110);
        drive(1'b1, 32'd5, 32'd5, 32'd0);
        cyc();
        chk("t2_zero", 32'(out_flags), 32'b00001);

        // Signed overflow, then corrupted diff
        drive(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        cyc();
        chk("t3_ovf", 32'(out_flags), 32'b01110);
        drive(1'b1, 32'd0, 32'd0, 32'h0000_1234);
        cyc();
        chk("t3_err", 32'(out_flags), 32'b10000);
        drive(1'b0, '0, '0, '0);
        cyc();
        chk("t3_res_count", 32'(res_count), 32'd5);

        // Backpressure: two accepted, third refused, FIFO order
        out_ready = 1'b0;
        drive(1'b1, 32'd100, 32'd1, 32'd99);
        cyc();
        chk("t4_ready_after_1", 32'(in_ready), 32'd1);
        drive(1'b1, 32'd200, 32'd2, 32'd198);
        cyc();
        chk("t4_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'd300, 32'd3, 32'd297);
        cyc();
        chk("t4_held_diff", out_diff, 32'd99);
        chk("t4_still_full", 32'(in_ready), 32'd0);
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        cyc();
        chk("t4_second_out", out_diff, 32'd198);
        chk("t4_second_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("t4_drained", 32'(out_valid), 32'd0);
        chk("t4_res_count", 32'(res_count), 32'd7);

        // 100 back-to-back results at full rate
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            drive(1'b1, a, b, a - b);
            cyc();
            chk("t5_ready", 32'(in_ready), 32'd1);
            chk("t5_diff", out_diff, a - b);
        end
        drive(1'b0, '0, '0, '0);
        cyc();
        chk("t5_res_count", 32'(res_count), 32'd107);

        // Reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 32'd9, 32'd4, 32'd5);
        cyc();
        cyc();
        chk("t6_full", 32'(in_ready), 32'd0);
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        cyc();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_res_count", 32'(res_count), 32'd0);
        rst = 1'b0;
        cyc();
        chk("t6_in_ready", 32'(in_ready), 32'd1);

`ifdef SUB_STAGE_STICKY_EN
        // Sticky set, clear, and set-wins-over-clear
        out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        cyc();
        chk("t6_sticky_set", 32'(sticky_err), 32'd1);
        drive(1'b0, '0, '0, '0);
        clr_sticky = 1'b1;
        cyc();
        chk("t6_sticky_clr", 32'(sticky_err), 32'd0);
        drive(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        cyc();
        chk("t6_sticky_set_wins", 32'(sticky_err), 32'd1);
        clr_sticky = 1'b0;
        drive(1'b0, '0, '0, '0);
        cyc();
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b, d;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) begin
                a = 32'($urandom_range(0, 3));
                b = 32'($urandom_range(0, 3));
            end
            d = ($urandom_range(0, 7) == 0) ? $urandom : a - b;
            drive($urandom_range(0, 3) != 0, a, b, d);
            out_ready  = (i % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 1) != 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        cyc();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
